tinyyolohw_rd_burst_ctrl: RTL and testbench
===========================================

TINYYOLOHW_RD_BURST_CTRL -- requirements
Module: tinyyolohw_rd_burst_ctrl

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 64, AXI address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 512, AXI/AXIS data width in bits (power of 2, >=32).
REQ-003 SHALL have parameter C_XFER_SIZE_WIDTH, default 32, byte-count width.
REQ-004 SHALL have parameter C_BURST_LEN, default 64, max beats per burst (1..256).
REQ-005 SHALL have parameter C_MAX_OUTSTANDING, default 16, max in-flight bursts (1..255).
REQ-006 SHALL have ports:
  aclk  in  1  clock, all logic rising-edge.
  areset  in  1  reset, synchronous, active-high.
  ctrl_start  in  1  one-cycle start pulse.
  ctrl_done  out  1  one-cycle completion pulse.
  ctrl_addr_offset  in  C_ADDR_WIDTH  start byte address, aligned to C_BURST_LEN*C_DATA_WIDTH/8.
  ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  transfer length in bytes.
  m_axi_arvalid/arready  out/in  1  AR handshake.
  m_axi_araddr  out  C_ADDR_WIDTH  burst address.
  m_axi_arlen  out  8  burst beats minus one.
  m_axi_rvalid/rready  in/out  1  R handshake.
  m_axi_rdata  in  C_DATA_WIDTH  read data.
  m_axi_rlast  in  1  last beat of burst.
  m_axis_tvalid/tready  out/in  1  AXIS handshake to compute pipeline.
  m_axis_tdata  out  C_DATA_WIDTH  stream data.
  m_axis_tlast  out  1  last beat of whole transfer.

Function
REQ-007 SHALL sample ctrl_addr_offset and ctrl_xfer_size_in_bytes when ctrl_start is high in IDLE; ctrl_start outside IDLE SHALL be ignored.
REQ-008 SHALL compute total beats = ceil(bytes / (C_DATA_WIDTH/8)) and bursts = ceil(beats / C_BURST_LEN); all bursts full length except the last, whose arlen = remainder beats minus 1.
REQ-009 SHALL implement FSM IDLE -> ISSUE (start, beats>0) -> DRAIN (last AR handshake) -> DONE (final rlast handshake, outstanding reaches zero) -> IDLE (next cycle); IDLE -> DONE directly when beats = 0.
REQ-010 SHALL drive m_axi_arvalid first at the cycle after ctrl_start; araddr increments by C_BURST_LEN*C_DATA_WIDTH/8 per AR handshake.
REQ-011 SHALL hold arvalid, araddr, arlen stable until arready.
REQ-012 SHALL track outstanding bursts: +1 on AR handshake, -1 on R handshake with rlast, unchanged when both occur in the same cycle.
REQ-013 SHALL deassert arvalid (not mid-handshake) while outstanding = C_MAX_OUTSTANDING and not issue a new AR until a decrement.
REQ-014 SHALL connect R to AXIS combinationally: tvalid = rvalid, rready = tready, tdata = rdata; zero added latency.
REQ-015 SHALL assert tlast only on the final beat of the final burst, counted by a beat counter independent of rlast.
REQ-016 SHALL pulse ctrl_done for exactly one cycle, the cycle after the final R handshake (or two cycles after ctrl_start for zero-byte transfers).

Reset
REQ-017 SHALL on areset return FSM to IDLE, clear outstanding, burst and beat counters, and drive arvalid=0, ctrl_done=0, araddr=0, arlen=0 the following cycle.
REQ-018 SHALL abandon a transfer when areset asserts mid-operation; no ctrl_done for that transfer.

Configuration
REQ-019 SHALL, with TINYYOLOHW_RD_PERF_CNT_EN defined, add output perf_stall_cycles (32 bits) counting cycles in ISSUE/DRAIN with outstanding = C_MAX_OUTSTANDING or (rvalid & ~tready); cleared on ctrl_start and areset, saturating at all-ones.
REQ-020 SHALL, without TINYYOLOHW_RD_PERF_CNT_EN, omit the port and counter logic entirely.

Structure
REQ-021 SHALL place FSM state enum and beat-width/burst-byte helper constants in package tinyyolohw_rd_pkg.
REQ-022 SHALL instantiate the codebase's generic up/down counter (load, incr, decr, is_zero) as the outstanding-burst tracker; no other sub-module.

Verification (C_DATA_WIDTH=512, C_BURST_LEN=64)
REQ-023 SHALL cover 4096 bytes, addr 0x1000 -> one AR araddr=0x1000 arlen=63; 64 beats; tlast on beat 64; ctrl_done one cycle after.
REQ-024 SHALL cover 8256 bytes -> ARs arlen 63,63,0 at +0x0,+0x1000,+0x2000; 129 beats, tlast only on beat 129.
REQ-025 SHALL cover C_MAX_OUTSTANDING=2, 16384 bytes, rvalid held low -> exactly 2 ARs, arvalid then low; first rlast -> third AR.
REQ-026 SHALL cover 0 bytes -> no AR, no tvalid, ctrl_done two cycles after ctrl_start.
REQ-027 SHALL cover areset asserted after second AR of 8256-byte run -> arvalid=0, ctrl_done never asserted; new 64-byte start then yields arlen=0 and ctrl_done.
REQ-028 SHALL cover (TINYYOLOHW_RD_PERF_CNT_EN) tready low 10 cycles with rvalid high -> perf_stall_cycles = 10.

Source files
------------

// File: rtl/tinyyolohw_rd_pkg.sv
// Shared types and size helpers for the tinyyolohw read-burst controller.
// Elaboration-time functions only; no state lives here.
package tinyyolohw_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

  function automatic int beat_bytes(input int dw);
    return dw / 8;
  endfunction

  function automatic int beat_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int burst_bytes(input int dw, input int bl);
    return bl * (dw / 8);
  endfunction

endpackage

// File: rtl/tinyyolohw_rd_burst_ctrl_cnt.sv
// Generic up/down counter with synchronous load and zero flag.
// Simultaneous incr and decr leave the count unchanged.
module tinyyolohw_rd_burst_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         incr_i,
  input  logic         decr_i,
  output logic [W-1:0] cnt_o,
  output logic         is_zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (incr_i && !decr_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (decr_i && !incr_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/tinyyolohw_rd_burst_ctrl.sv
// AXI read-burst issuer streaming R data straight onto AXIS.
// Define TINYYOLOHW_RD_PERF_CNT_EN to add the perf_stall_cycles counter.
module tinyyolohw_rd_burst_ctrl
  import tinyyolohw_rd_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         ctrl_start,
  output logic                         ctrl_done,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic                         m_axi_rlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                         m_axis_tlast
`ifdef TINYYOLOHW_RD_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_stall_cycles
`endif
);

  localparam int BSH = beat_shift(C_DATA_WIDTH);
  localparam int XW  = C_XFER_SIZE_WIDTH;
  localparam int AW  = C_ADDR_WIDTH;
  localparam int OW  = $clog2(C_MAX_OUTSTANDING + 1);

  localparam logic [XW-1:0] BL_X   = XW'(C_BURST_LEN);
  localparam logic [OW-1:0] MAX_O  = OW'(C_MAX_OUTSTANDING);
  localparam logic [AW-1:0] STEP_A =
    AW'(burst_bytes(C_DATA_WIDTH, C_BURST_LEN));

  function automatic logic [XW-1:0] blen(
    input logic [XW-1:0] n
  );
    return (n > BL_X) ? BL_X : n;
  endfunction

  function automatic logic [7:0] len_of(
    input logic [XW-1:0] n
  );
    return 8'(blen(n) - XW'(1));
  endfunction

  rd_state_e         state_q, state_d;
  logic [AW-1:0]     araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              arvalid_q, arvalid_d;
  logic [XW-1:0]     ar_rem_q, ar_rem_d;
  logic [XW-1:0]     r_rem_q, r_rem_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;

  logic [XW-1:0]     beats_w;
  logic              start_ok;
  logic              active;
  logic              ar_hs;
  logic              r_hs;
  logic              ost_inc;
  logic              ost_dec;
  logic [OW-1:0]     ost_q;
  logic [OW-1:0]     ost_nxt;
  logic              ost_zero;
  logic              ost_drained;

  assign beats_w = (ctrl_xfer_size_in_bytes >> BSH)
                 + XW'(|ctrl_xfer_size_in_bytes[BSH-1:0]);

  assign start_ok = ctrl_start && (state_q == ST_IDLE);
  assign active   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign ar_hs    = arvalid_q && m_axi_arready;
  assign r_hs     = m_axi_rvalid && m_axis_tready;
  assign ost_inc  = ar_hs;
  assign ost_dec  = r_hs && m_axi_rlast && active;
  assign ost_nxt  = ost_q + OW'(ost_inc) - OW'(ost_dec);

  // Outstanding reaches zero on this beat when the last burst retires.
  assign ost_drained = ost_dec ? (ost_q == OW'(1)) : ost_zero;

  tinyyolohw_rd_burst_ctrl_cnt #(
    .W (OW)
  ) u_ost (
    .clk_i      (aclk),
    .rst_i      (areset),
    .load_i     (start_ok),
    .load_val_i ('0),
    .incr_i     (ost_inc),
    .decr_i     (ost_dec),
    .cnt_o      (ost_q),
    .is_zero_o  (ost_zero)
  );

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    ar_rem_d  = ar_rem_q;
    r_rem_d   = r_rem_q;
    done_d    = 1'b0;
    zero_d    = 1'b0;

    if (active && r_hs && (r_rem_q != '0)) begin
      r_rem_d = r_rem_q - 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          if (beats_w == '0) begin
            state_d = ST_DONE;
            zero_d  = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            araddr_d  = ctrl_addr_offset;
            arlen_d   = len_of(beats_w);
            ar_rem_d  = beats_w - blen(beats_w);
            r_rem_d   = beats_w;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (ar_hs && (ar_rem_q == '0)) begin
          arvalid_d = 1'b0;
          state_d   = ST_DRAIN;
        end else if (ar_hs || !arvalid_q) begin
          if (ar_hs) begin
            araddr_d = araddr_q + STEP_A;
            arlen_d  = len_of(ar_rem_q);
            ar_rem_d = ar_rem_q - blen(ar_rem_q);
          end
          // Park the next AR until a burst retires.
          arvalid_d = (ost_nxt < MAX_O);
        end
      end
      ST_DRAIN: begin
        if (r_hs && (r_rem_q == XW'(1)) && ost_drained) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = zero_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
      ar_rem_q  <= '0;
      r_rem_q   <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      ar_rem_q  <= ar_rem_d;
      r_rem_q   <= r_rem_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
    end
  end

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign ctrl_done     = done_q;

  assign m_axis_tvalid = m_axi_rvalid;
  assign m_axi_rready  = m_axis_tready;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = active && (r_rem_q == XW'(1));

`ifdef TINYYOLOHW_RD_PERF_CNT_EN
  logic [31:0] perf_q;
  logic        stall;

  assign stall = active &&
    ((ost_q == MAX_O) || (m_axi_rvalid && !m_axis_tready));

  always_ff @(posedge aclk) begin
    if (areset || start_ok) begin
      perf_q <= '0;
    end else if (stall && !(&perf_q)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tinyyolohw_rd_burst_ctrl.sv
// Scoreboard bench for tinyyolohw_rd_burst_ctrl with a small AXI slave.
// Expected ARs, beats and done timing are queued by the directed tests.
module tb_tinyyolohw_rd_burst_ctrl;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 32;
  localparam int BL = 64;
  localparam int MO = 2;

  logic          aclk;
  logic          areset;
  logic          ctrl_start;
  logic          ctrl_done;
  logic [AW-1:0] ctrl_addr_offset;
  logic [XW-1:0] ctrl_xfer_size_in_bytes;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
`ifdef TINYYOLOHW_RD_PERF_CNT_EN
  logic [31:0]   perf;
`endif

  tinyyolohw_rd_burst_ctrl #(
    .C_ADDR_WIDTH      (AW),
    .C_DATA_WIDTH      (DW),
    .C_XFER_SIZE_WIDTH (XW),
    .C_BURST_LEN       (BL),
    .C_MAX_OUTSTANDING (MO)
  ) dut (
`ifdef TINYYOLOHW_RD_PERF_CNT_EN
    .perf_stall_cycles       (perf),
`endif
    .aclk                    (aclk),
    .areset                  (areset),
    .ctrl_start              (ctrl_start),
    .ctrl_done               (ctrl_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .m_axi_arvalid           (m_axi_arvalid),
    .m_axi_arready           (m_axi_arready),
    .m_axi_araddr            (m_axi_araddr),
    .m_axi_arlen             (m_axi_arlen),
    .m_axi_rvalid            (m_axi_rvalid),
    .m_axi_rready            (m_axi_rready),
    .m_axi_rdata             (m_axi_rdata),
    .m_axi_rlast             (m_axi_rlast),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tlast            (m_axis_tlast)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } bt_t;

  ar_t exp_ar[$];
  bt_t exp_bt[$];
  int  exp_done[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ar_cnt = 0;
  int ar3_cyc = -1;
  int first_rl_cyc = -1;
  int last_cyc = -1;

  int unsigned sl_len[$];
  int          bidx = 0;
  int unsigned bctr = 0;
  bit          r_en = 1'b1;
  bit          ar_thr = 1'b0;

  function automatic logic [DW-1:0] pat(input int unsigned n);
    logic [31:0] w;
    w = 32'hC0DE_0000 + n;
    return {(DW/32){w}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_ar(input logic [AW-1:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_ar.push_back(e);
  endtask

  task automatic push_beats(input int n);
    bt_t e;
    for (int i = 0; i < n; i++) begin
      e.data = pat(i);
      e.last = (i == n - 1);
      exp_bt.push_back(e);
    end
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [XW-1:0] b);
    ctrl_addr_offset        = a;
    ctrl_xfer_size_in_bytes = b;
    ctrl_start              = 1'b1;
    tick(1);
    ctrl_start = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while ((exp_ar.size() + exp_bt.size() + exp_done.size()) != 0
           && k < lim) begin
      tick(1);
      k++;
    end
    chk("scoreboard_drained",
        64'(exp_ar.size() + exp_bt.size() + exp_done.size()), 64'(0));
    exp_ar.delete();
    exp_bt.delete();
    exp_done.delete();
    tick(4);
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    forever begin
      @(posedge aclk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // AXI slave: accepts ARs, returns bursts in order with patterned data.
  initial begin
    logic       arh;
    logic [7:0] arl;
    logic       rh;
    logic       rl;
    logic       rs;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rlast   = 1'b0;
    forever begin
      @(negedge aclk);
      arh = m_axi_arvalid && m_axi_arready;
      arl = m_axi_arlen;
      rh  = m_axi_rvalid && m_axi_rready;
      rl  = m_axi_rlast;
      rs  = areset;
      @(posedge aclk);
      #1;
      if (rs) begin
        sl_len.delete();
        bidx = 0;
      end else begin
        if (rh) begin
          if (rl) begin
            void'(sl_len.pop_front());
            bidx = 0;
          end else begin
            bidx++;
          end
          bctr++;
        end
        if (arh) sl_len.push_back({24'd0, arl});
      end
      m_axi_arready = !ar_thr || (cyc % 3 == 0);
      m_axi_rvalid  = r_en && (sl_len.size() > 0);
      m_axi_rdata   = pat(bctr);
      m_axi_rlast   = (sl_len.size() > 0) && (bidx == int'(sl_len[0]));
    end
  end

  // Monitor: pops and compares whenever the DUT presents an output.
  initial begin
    bit            ar_wait;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_len;
    ar_t           ea;
    bt_t           eb;
    int            e;
    int            want;
    ar_wait = 1'b0;
    w_addr  = '0;
    w_len   = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        ar_wait = 1'b0;
      end else begin
        if (ar_wait) begin
          chk("ar_hold_valid", 64'(m_axi_arvalid), 64'(1));
          chk("ar_hold_addr", m_axi_araddr, w_addr);
          chk("ar_hold_len", 64'(m_axi_arlen), 64'(w_len));
        end
        if (m_axi_arvalid && m_axi_arready) begin
          ar_cnt++;
          if (ar_cnt == 3) ar3_cyc = cyc;
          chk("ar_expected", 64'(exp_ar.size() > 0), 64'(1));
          if (exp_ar.size() > 0) begin
            ea = exp_ar.pop_front();
            chk("araddr", m_axi_araddr, ea.addr);
            chk("arlen", 64'(m_axi_arlen), 64'(ea.len));
          end
        end
        ar_wait = m_axi_arvalid && !m_axi_arready;
        w_addr  = m_axi_araddr;
        w_len   = m_axi_arlen;
        if (m_axi_rvalid || m_axis_tvalid) begin
          chk("tvalid_pass", 64'(m_axis_tvalid), 64'(m_axi_rvalid));
          chk("rready_pass", 64'(m_axi_rready), 64'(m_axis_tready));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (m_axi_rlast && first_rl_cyc < 0) first_rl_cyc = cyc;
          chk("beat_expected", 64'(exp_bt.size() > 0), 64'(1));
          if (exp_bt.size() > 0) begin
            eb = exp_bt.pop_front();
            chk("tdata_lo", m_axis_tdata[63:0], eb.data[63:0]);
            chk("tdata_hi", m_axis_tdata[DW-1 -: 64], eb.data[DW-1 -: 64]);
            chk("tlast", 64'(m_axis_tlast), 64'(eb.last));
            if (eb.last) last_cyc = cyc;
          end
        end
        if (ctrl_done) begin
          chk("done_expected", 64'(exp_done.size() > 0), 64'(1));
          if (exp_done.size() > 0) begin
            e    = exp_done.pop_front();
            want = (e < 0) ? last_cyc + 1 : e;
            chk("done_cycle", 64'(cyc), 64'(want));
          end
        end
      end
    end
  end

  initial begin
    int k;
    areset                  = 1'b1;
    ctrl_start              = 1'b0;
    ctrl_addr_offset        = '0;
    ctrl_xfer_size_in_bytes = '0;
    m_axis_tready           = 1'b1;
    tick(3);
    @(negedge aclk);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_done", 64'(ctrl_done), 64'(0));
    chk("rst_araddr", m_axi_araddr, 64'(0));
    chk("rst_arlen", 64'(m_axi_arlen), 64'(0));
    tick(1);
    areset = 1'b0;
    tick(2);

    // Single full burst; a second start mid-run must be ignored.
    bctr = 0;
    push_ar(64'h1000, 8'd63);
    push_beats(64);
    exp_done.push_back(-1);
    start(64'h1000, 32'd4096);
    tick(5);
    start(64'h5000, 32'd8256);
    wait_idle(500);

    // Two full bursts plus a one-beat tail, with a throttled arready.
    ar_thr = 1'b1;
    bctr   = 0;
    push_ar(64'h0000, 8'd63);
    push_ar(64'h1000, 8'd63);
    push_ar(64'h2000, 8'd0);
    push_beats(129);
    exp_done.push_back(-1);
    start(64'h0, 32'd8256);
    wait_idle(1000);
    ar_thr = 1'b0;

    // Outstanding limit of two with R held off.
    r_en         = 1'b0;
    bctr         = 0;
    ar_cnt       = 0;
    ar3_cyc      = -1;
    first_rl_cyc = -1;
    push_ar(64'h10000, 8'd63);
    push_ar(64'h11000, 8'd63);
    push_ar(64'h12000, 8'd63);
    push_ar(64'h13000, 8'd63);
    push_beats(256);
    exp_done.push_back(-1);
    start(64'h10000, 32'd16384);
    tick(20);
    @(negedge aclk);
    chk("max_out_ar_count", 64'(ar_cnt), 64'(2));
    chk("max_out_arvalid", 64'(m_axi_arvalid), 64'(0));
    tick(1);
    r_en = 1'b1;
    wait_idle(2000);
    chk("third_ar_after_rlast", 64'(ar3_cyc > first_rl_cyc), 64'(1));

    // Zero-byte transfer: done two cycles after start, no AR.
    exp_done.push_back(cyc + 2);
    start(64'h2000, 32'd0);
    wait_idle(20);

    // Reset after the second AR abandons the transfer.
    r_en   = 1'b0;
    ar_cnt = 0;
    push_ar(64'h0000, 8'd63);
    push_ar(64'h1000, 8'd63);
    start(64'h0, 32'd8256);
    k = 0;
    while (ar_cnt < 2 && k < 50) begin
      tick(1);
      k++;
    end
    chk("abort_two_ars", 64'(ar_cnt), 64'(2));
    tick(2);
    areset = 1'b1;
    tick(1);
    @(negedge aclk);
    chk("abort_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("abort_araddr", m_axi_araddr, 64'(0));
    chk("abort_arlen", 64'(m_axi_arlen), 64'(0));
    tick(1);
    areset = 1'b0;
    r_en   = 1'b1;
    tick(20);
    chk("abort_ar_left", 64'(exp_ar.size()), 64'(0));
    bctr = 0;
    push_ar(64'h3000, 8'd0);
    push_beats(1);
    exp_done.push_back(-1);
    start(64'h3000, 32'd64);
    wait_idle(100);

`ifdef TINYYOLOHW_RD_PERF_CNT_EN
    // Ten cycles of rvalid against a low tready.
    r_en   = 1'b0;
    bctr   = 0;
    ar_cnt = 0;
    push_ar(64'h4000, 8'd63);
    push_beats(64);
    exp_done.push_back(-1);
    start(64'h4000, 32'd4096);
    k = 0;
    while (ar_cnt < 1 && k < 50) begin
      tick(1);
      k++;
    end
    m_axis_tready = 1'b0;
    r_en          = 1'b1;
    k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (!m_axi_rvalid && k < 50);
    repeat (10) @(posedge aclk);
    #1;
    m_axis_tready = 1'b1;
    wait_idle(500);
    chk("perf_stall", 64'(perf), 64'(10));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
